// File: rtl/snes_pad_responder.sv
// snes_pad_responder
//   Device-side model of an SNES-style gamepad. Answers the latch/pulse
//   sequence from the controller block and returns 16 button bits, LSB first,
//   on an active-low serial data line.
//
// Ports:
//   I_CLK               block clock (>= 8x pulse frequency)
//   I_RESET             asynchronous active-high reset
//   I_CONTROLLER_LATCH  latch from initiator (asynchronous to I_CLK)
//   I_CONTROLLER_PULSE  shift clock from initiator (asynchronous to I_CLK)
//   I_BUTTONS[11:0]     pressed=1; B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R
//   O_CONTROLLER_DATA   serial data, 0 = pressed (registered)
//   O_BIT_COUNT[4:0]    bits shifted in the current frame, 0..16
//   O_FRAME_DONE        one-cycle pulse on the 16th shift
//   O_PROTO_ERR         one-cycle pulse on a protocol violation
module snes_pad_responder #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         FILTER_CYCLES = 2,
  parameter int         NUM_BITS      = 16,
  parameter logic [3:0] PAD_ID        = 4'b0000
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_CONTROLLER_LATCH,
  input  logic        I_CONTROLLER_PULSE,
  input  logic [11:0] I_BUTTONS,
  output logic        O_CONTROLLER_DATA,
  output logic [4:0]  O_BIT_COUNT,
  output logic        O_FRAME_DONE,
  output logic        O_PROTO_ERR
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LATCHED  = 2'd1,
    SHIFTING = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Channel index 0 = latch, 1 = pulse.
  logic [SYNC_STAGES-1:0] latch_sync_r;
  logic [SYNC_STAGES-1:0] pulse_sync_r;
  logic [1:0]             synced_s;
  logic [1:0]             filt_lvl_r;
  logic [1:0]             filt_prev_r;
  logic [CW-1:0]          filt_cnt_r [2];

  logic latch_rise_s;
  logic latch_fall_s;
  logic pulse_rise_s;

  state_t      state_r, state_n;
  logic [15:0] sr_r, sr_n;
  logic [4:0]  cnt_n;
  logic        data_n, done_n, err_n;
  logic [15:0] load_s;

  // Metastability synchronizers for the two asynchronous inputs.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      latch_sync_r <= '0;
      pulse_sync_r <= '0;
    end else begin
      latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], I_CONTROLLER_LATCH};
      pulse_sync_r <= {pulse_sync_r[SYNC_STAGES-2:0], I_CONTROLLER_PULSE};
    end
  end

  assign synced_s = {pulse_sync_r[SYNC_STAGES-1], latch_sync_r[SYNC_STAGES-1]};

  // Glitch filter: a new level is accepted only after FILTER_CYCLES
  // consecutive synchronized samples disagree with the current level.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      filt_lvl_r  <= 2'b00;
      filt_prev_r <= 2'b00;
      for (int i = 0; i < 2; i++) filt_cnt_r[i] <= '0;
    end else begin
      filt_prev_r <= filt_lvl_r;
      for (int i = 0; i < 2; i++) begin
        if (synced_s[i] != filt_lvl_r[i]) begin
          if (filt_cnt_r[i] == CW'(FILTER_CYCLES - 1)) begin
            filt_lvl_r[i] <= synced_s[i];
            filt_cnt_r[i] <= '0;
          end else begin
            filt_cnt_r[i] <= filt_cnt_r[i] + CW'(1);
          end
        end else begin
          filt_cnt_r[i] <= '0;
        end
      end
    end
  end

  assign latch_rise_s = filt_lvl_r[0] & ~filt_prev_r[0];
  assign latch_fall_s = ~filt_lvl_r[0] & filt_prev_r[0];
  assign pulse_rise_s = filt_lvl_r[1] & ~filt_prev_r[1];
  assign load_s       = {PAD_ID, I_BUTTONS};

  // Next-state, shift register and output computation.
  always_comb begin
    state_n = state_r;
    sr_n    = sr_r;
    cnt_n   = O_BIT_COUNT;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (latch_rise_s) begin
          // Latch wins over a simultaneous pulse.
          state_n = LATCHED;
          sr_n    = load_s;
          cnt_n   = 5'd0;
        end else if (pulse_rise_s) begin
          err_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      LATCHED: begin
        if (latch_fall_s) begin
          // Buttons are frozen from the last latched cycle.
          state_n = SHIFTING;
        end else begin
          sr_n  = load_s;
          cnt_n = 5'd0;
          if (pulse_rise_s) begin
            err_n = 1'b1;
          end else begin
            err_n = 1'b0;
          end
        end
      end
      SHIFTING: begin
        if (latch_rise_s) begin
          // Early abort of an incomplete frame.
          state_n = LATCHED;
          sr_n    = load_s;
          cnt_n   = 5'd0;
          err_n   = 1'b1;
        end else if (pulse_rise_s) begin
          sr_n  = {1'b1, sr_r[15:1]};
          cnt_n = O_BIT_COUNT + 5'd1;
          if (O_BIT_COUNT == 5'(NUM_BITS - 1)) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = SHIFTING;
          end
        end else begin
          state_n = SHIFTING;
        end
      end
      DONE: begin
        if (latch_rise_s) begin
          state_n = LATCHED;
          sr_n    = load_s;
          cnt_n   = 5'd0;
        end else if (pulse_rise_s) begin
          // Trailing 1s keep the line low: pad-present indication.
          sr_n = {1'b1, sr_r[15:1]};
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
        sr_n    = 16'h0000;
        cnt_n   = 5'd0;
      end
    endcase
    data_n = ~sr_n[0];
  end

  // State, shift register and registered outputs.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_r           <= IDLE;
      sr_r              <= 16'h0000;
      O_CONTROLLER_DATA <= 1'b1;
      O_BIT_COUNT       <= 5'd0;
      O_FRAME_DONE      <= 1'b0;
      O_PROTO_ERR       <= 1'b0;
    end else begin
      state_r           <= state_n;
      sr_r              <= sr_n;
      O_CONTROLLER_DATA <= data_n;
      O_BIT_COUNT       <= cnt_n;
      O_FRAME_DONE      <= done_n;
      O_PROTO_ERR       <= err_n;
    end
  end

endmodule

// File: tb/tb_snes_pad_responder.sv
`timescale 1ns/1ps
module tb_snes_pad_responder;

  logic        clk;
  logic        rst;
  logic        latch;
  logic        pulse;
  logic [11:0] buttons;
  logic        data;
  logic [4:0]  bit_count;
  logic        frame_done;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_base;
  int err_base;
  logic [15:0] ld;

  snes_pad_responder dut (
    .I_CLK              (clk),
    .I_RESET            (rst),
    .I_CONTROLLER_LATCH (latch),
    .I_CONTROLLER_PULSE (pulse),
    .I_BUTTONS          (buttons),
    .O_CONTROLLER_DATA  (data),
    .O_BIT_COUNT        (bit_count),
    .O_FRAME_DONE       (frame_done),
    .O_PROTO_ERR        (proto_err)
  );

  // 10 MHz clock; pulse period of 6 us is far below 1/8 of it.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Count single-cycle output pulses away from the active edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (proto_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_pulse();
    pulse = 1'b1;
    #3000;
    pulse = 1'b0;
    #3000;
  endtask

  task automatic start_frame(input logic [11:0] b);
    buttons = b;
    latch = 1'b1;
    #12000;
    latch = 1'b0;
    #3000;
  endtask

  // Before each pulse: line shows the next bit (inverted), count = bits done.
  task automatic shift_bits(input int first, input int last, input logic [15:0] lv);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      check($sformatf("line_bit%0d", i), {31'd0, data}, {31'd0, ~lv[i]});
      check($sformatf("count_bit%0d", i), {27'd0, bit_count}, i);
      do_pulse();
    end
  endtask

  initial begin
    rst = 1'b1; latch = 1'b0; pulse = 1'b0; buttons = 12'h000;
    #250;
    rst = 1'b0;
    #1000;
    @(negedge clk);
    // 1. idle after reset
    check("idle_data", {31'd0, data}, 32'd1);
    check("idle_count", {27'd0, bit_count}, 32'd0);
    check("idle_done", done_cnt, 32'd0);
    check("idle_err", err_cnt, 32'd0);

    // 5a. pulse while idle is a protocol error, line unchanged
    do_pulse();
    @(negedge clk);
    check("idle_pulse_err", err_cnt, 32'd1);
    check("idle_pulse_data", {31'd0, data}, 32'd1);
    check("idle_pulse_count", {27'd0, bit_count}, 32'd0);

    // 2. normal frame with 0x0A5; buttons change after latch has no effect
    ld = {4'b0000, 12'h0A5};
    buttons = 12'h0A5;
    latch = 1'b1;
    #6000;
    @(negedge clk);
    check("latched_data", {31'd0, data}, {31'd0, ~ld[0]});
    check("latched_count", {27'd0, bit_count}, 32'd0);
    #6000;
    latch = 1'b0;
    #3000;
    buttons = 12'h000;
    done_base = done_cnt;
    err_base = err_cnt;
    shift_bits(0, 15, ld);
    @(negedge clk);
    check("f1_end_data", {31'd0, data}, 32'd0);
    check("f1_end_count", {27'd0, bit_count}, 32'd16);
    check("f1_done_once", done_cnt - done_base, 32'd1);
    check("f1_no_err", err_cnt - err_base, 32'd0);

    // 3. extra pulses after the frame
    do_pulse();
    do_pulse();
    @(negedge clk);
    check("extra_data", {31'd0, data}, 32'd0);
    check("extra_count", {27'd0, bit_count}, 32'd16);
    check("extra_no_err", err_cnt - err_base, 32'd0);
    check("extra_no_done", done_cnt - done_base, 32'd1);

    // 4. abort after 5 pulses with all buttons pressed
    ld = {4'b0000, 12'hFFF};
    start_frame(12'hFFF);
    shift_bits(0, 4, ld);
    err_base = err_cnt;
    latch = 1'b1;
    #1000;
    @(negedge clk);
    check("abort_err", err_cnt - err_base, 32'd1);
    check("abort_count", {27'd0, bit_count}, 32'd0);
    check("abort_data", {31'd0, data}, 32'd0);
    #11000;
    latch = 1'b0;
    #3000;
    done_base = done_cnt;
    shift_bits(0, 15, ld);
    @(negedge clk);
    check("f2_end_data", {31'd0, data}, 32'd0);
    check("f2_done_once", done_cnt - done_base, 32'd1);

    // 5b. one-cycle glitch on pulse is filtered out
    ld = {4'b0000, 12'h0A5};
    start_frame(12'h0A5);
    shift_bits(0, 1, ld);
    @(negedge clk);
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    #3000;
    @(negedge clk);
    check("glitch_count", {27'd0, bit_count}, 32'd2);
    shift_bits(2, 15, ld);
    @(negedge clk);
    check("f3_end_count", {27'd0, bit_count}, 32'd16);

    // 5c. same-cycle latch and pulse from DONE: reload only, no error
    err_base = err_cnt;
    latch = 1'b1;
    pulse = 1'b1;
    #1000;
    @(negedge clk);
    check("same_count", {27'd0, bit_count}, 32'd0);
    check("same_data", {31'd0, data}, {31'd0, ~ld[0]});
    check("same_no_err", err_cnt - err_base, 32'd0);
    pulse = 1'b0;
    #11000;
    latch = 1'b0;
    #3000;

    // 6. asynchronous reset after 7 pulses
    shift_bits(0, 6, ld);
    @(posedge clk);
    #30;
    rst = 1'b1;
    #1;
    check("rst_data", {31'd0, data}, 32'd1);
    check("rst_count", {27'd0, bit_count}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_err", {31'd0, proto_err}, 32'd0);
    #200;
    rst = 1'b0;
    #1000;
    ld = {4'b0000, 12'h35C};
    done_base = done_cnt;
    start_frame(12'h35C);
    shift_bits(0, 15, ld);
    @(negedge clk);
    check("f4_end_data", {31'd0, data}, 32'd0);
    check("f4_end_count", {27'd0, bit_count}, 32'd16);
    check("f4_done_once", done_cnt - done_base, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
